// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer. One M-extension op per start
// pulse: radix-2 shift-add multiply or restoring divide over XLEN cycles,
// then a sign-fix cycle and a one-cycle done pulse with a registered result.
//
// state | meaning
// IDLE  | waiting for start; special-case divides finish directly to DONE
// CALC  | one multiply/divide iteration per cycle, counter XLEN-1 down to 0
// FIX   | sign correction and half selection, result written
// DONE  | done pulse; a new start is accepted here as in IDLE
module mdu_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]     cnt;
   logic [2:0]        op_q;
   logic              neg_prod;   // negate product or quotient
   logic              neg_rem;
   logic [XLEN-1:0]   mag;        // |op_a| multiplicand, or |op_b| divisor
   logic [2*XLEN-1:0] work;       // product register; low half is quotient for divides
   logic [XLEN:0]     rem;        // extra bit keeps the subtract borrow visible

   logic            accept, a_signed, b_signed, sign_a, sign_b, special;
   logic [XLEN-1:0] abs_a, abs_b, special_res;

   logic [XLEN:0]     add_sum, rem_shift, rem_diff;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

   assign busy = (state == S_CALC) || (state == S_FIX);
   assign done = (state == S_DONE);

   // Accept decode: operand signedness, magnitudes and divide special cases.
   always_comb begin
      accept      = start & ~kill & ((state == S_IDLE) || (state == S_DONE));
      a_signed    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
      b_signed    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      sign_a      = a_signed & op_a[XLEN-1];
      sign_b      = b_signed & op_b[XLEN-1];
      abs_a       = sign_a ? -op_a : op_a;
      abs_b       = sign_b ? -op_b : op_b;
      special     = 1'b0;
      special_res = '0;
      if (funct3[2] && (op_b == '0)) begin
         special     = 1'b1;
         special_res = funct3[1] ? op_a : '1;
      end else if (funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1)) begin
         special     = 1'b1;
         special_res = funct3[1] ? '0 : op_a;
      end
   end

   // One iteration step for both datapaths plus the FIX-cycle result select.
   always_comb begin
      add_sum   = {1'b0, work[2*XLEN-1:XLEN]} + {1'b0, (work[0] ? mag : {XLEN{1'b0}})};
      rem_shift = (rem << 1) | {{XLEN{1'b0}}, work[XLEN-1]};
      rem_diff  = rem_shift - {1'b0, mag};
      prod_fix  = neg_prod ? -work : work;
      quo_fix   = neg_prod ? -work[XLEN-1:0] : work[XLEN-1:0];
      rem_fix   = neg_rem ? -rem[XLEN-1:0] : rem[XLEN-1:0];
      if (!op_q[2])
         fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      else
         fix_res = op_q[1] ? rem_fix : quo_fix;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; kill aborts CALC/FIX but never cuts a done pulse short.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) state_nxt = special ? S_DONE : S_CALC;
            else        state_nxt = S_IDLE;
         end
         S_CALC: begin
            if (kill)            state_nxt = S_IDLE;
            else if (cnt == '0)  state_nxt = S_FIX;
         end
         S_FIX:   state_nxt = kill ? S_IDLE : S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, iteration registers and the result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         op_q     <= '0;
         neg_prod <= 1'b0;
         neg_rem  <= 1'b0;
         mag      <= '0;
         work     <= '0;
         rem      <= '0;
         result   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  op_q     <= funct3;
                  cnt      <= CW'(XLEN-1);
                  neg_prod <= sign_a ^ sign_b;
                  neg_rem  <= sign_a;
                  rem      <= '0;
                  if (funct3[2]) begin
                     mag  <= abs_b;
                     work <= {{XLEN{1'b0}}, abs_a};
                  end else begin
                     mag  <= abs_a;
                     work <= {{XLEN{1'b0}}, abs_b};
                  end
                  if (special) result <= special_res;
               end
            end
            S_CALC: begin
               if (!kill) begin
                  cnt <= cnt - 1'b1;
                  if (!op_q[2]) begin
                     work <= {add_sum, work[XLEN-1:1]};
                  end else if (rem_diff[XLEN]) begin
                     rem             <= rem_shift;
                     work[XLEN-1:0]  <= {work[XLEN-2:0], 1'b0};
                  end else begin
                     rem             <= rem_diff;
                     work[XLEN-1:0]  <= {work[XLEN-2:0], 1'b1};
                  end
               end
            end
            S_FIX: begin
               if (!kill) result <= fix_res;
            end
            default: ;
         endcase
      end
   end
endmodule
